pfd_lock_ctrl: RTL and testbench

- Digital sequencer for the phase frequency detector (PFD) and its charge pump (CP) in the PLL.
- Controls PFD reset (rstb) and CP enable during start-up.
- Detects phase lock from sampled up/dn, declares lock or loss of lock, and times out failed acquisition.
- Runs in the reference-clock domain, next to the PFD in the PLL top.

---
 rtl/pfd_lock_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pfd_lock_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pfd_lock_ctrl.sv
// PFD / charge-pump start-up sequencer with lock detection, loss-of-lock and acquisition timeout.
// Optional macro PFD_LOCK_AUTORETRY_EN: FAIL auto-retries through PRST after 16 cycles.
module pfd_lock_ctrl #(
    parameter int unsigned RST_CYC    = 4,
    parameter int unsigned LOCK_CNT   = 64,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter int unsigned TIMEOUT    = 4096,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up_smp,
    input  logic       dn_smp,
    output logic       pfd_rstb,
    output logic       cp_en,
    output logic       locked,
    output logic       fail,
    output logic       unlock_pulse,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StPrst   = 3'd1,
        StAcq    = 3'd2,
        StLocked = 3'd3,
        StFail   = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] RstLast   = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] LockMax   = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] UnlockMax = CNT_W'(UNLOCK_CNT);
    localparam logic [CNT_W-1:0] TmoMax    = CNT_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
    logic             pfd_rstb_q, pfd_rstb_d;
    logic             cp_en_q, cp_en_d;
    logic             locked_q, locked_d;
    logic             fail_q, fail_d;
    logic             unlock_q, unlock_d;
    logic             bad;

`ifdef PFD_LOCK_AUTORETRY_EN
    logic [3:0] retry_wait_q, retry_wait_d;
    logic [3:0] retry_cnt_q, retry_cnt_d;
`endif

    assign bad = up_smp | dn_smp;

    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        good_cnt_d = good_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        unlock_d   = 1'b0;
`ifdef PFD_LOCK_AUTORETRY_EN
        retry_wait_d = retry_wait_q;
        retry_cnt_d  = retry_cnt_q;
`endif
        if (!en) begin
            state_d    = StIdle;
            rst_cnt_d  = '0;
            good_cnt_d = '0;
            tmo_cnt_d  = '0;
            bad_cnt_d  = '0;
`ifdef PFD_LOCK_AUTORETRY_EN
            retry_wait_d = '0;
            retry_cnt_d  = '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    state_d   = StPrst;
                    rst_cnt_d = '0;
                end
                StPrst: begin
                    if (rst_cnt_q >= RstLast) begin
                        state_d    = StAcq;
                        good_cnt_d = '0;
                        tmo_cnt_d  = '0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 1'b1;
                    end
                end
                StAcq: begin
                    good_cnt_d = bad ? '0 :
                                 (good_cnt_q >= LockMax) ? good_cnt_q : good_cnt_q + 1'b1;
                    tmo_cnt_d  = (tmo_cnt_q >= TmoMax) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
                    // Lock takes priority over a timeout landing on the same edge.
                    if (good_cnt_d >= LockMax) begin
                        state_d   = StLocked;
                        bad_cnt_d = '0;
                    end else if (tmo_cnt_d >= TmoMax) begin
                        state_d = StFail;
`ifdef PFD_LOCK_AUTORETRY_EN
                        retry_wait_d = '0;
`endif
                    end
                end
                StLocked: begin
                    bad_cnt_d = !bad ? '0 :
                                (bad_cnt_q >= UnlockMax) ? bad_cnt_q : bad_cnt_q + 1'b1;
                    if (bad_cnt_d >= UnlockMax) begin
                        state_d    = StAcq;
                        unlock_d   = 1'b1;
                        good_cnt_d = '0;
                        tmo_cnt_d  = '0;
                        bad_cnt_d  = '0;
                    end
                end
                StFail: begin
`ifdef PFD_LOCK_AUTORETRY_EN
                    if (retry_wait_q == 4'd15) begin
                        state_d      = StPrst;
                        rst_cnt_d    = '0;
                        retry_wait_d = '0;
                        retry_cnt_d  = (retry_cnt_q == 4'd15) ? retry_cnt_q : retry_cnt_q + 1'b1;
                    end else begin
                        retry_wait_d = retry_wait_q + 1'b1;
                    end
`endif
                end
                default: state_d = StIdle;
            endcase
        end

        // Outputs are decoded from the next state so they change on the transition edge.
        pfd_rstb_d = (state_d == StAcq) || (state_d == StLocked);
        cp_en_d    = pfd_rstb_d;
        locked_d   = (state_d == StLocked);
`ifdef PFD_LOCK_AUTORETRY_EN
        fail_d = (state_d == StFail) ||
                 (fail_q && (state_d != StIdle) && (state_d != StLocked));
`else
        fail_d = (state_d == StFail);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            rst_cnt_q  <= '0;
            good_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            bad_cnt_q  <= '0;
            pfd_rstb_q <= 1'b0;
            cp_en_q    <= 1'b0;
            locked_q   <= 1'b0;
            fail_q     <= 1'b0;
            unlock_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            good_cnt_q <= good_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            pfd_rstb_q <= pfd_rstb_d;
            cp_en_q    <= cp_en_d;
            locked_q   <= locked_d;
            fail_q     <= fail_d;
            unlock_q   <= unlock_d;
        end
    end

`ifdef PFD_LOCK_AUTORETRY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retry_wait_q <= '0;
            retry_cnt_q  <= '0;
        end else begin
            retry_wait_q <= retry_wait_d;
            retry_cnt_q  <= retry_cnt_d;
        end
    end
`endif

    assign pfd_rstb     = pfd_rstb_q;
    assign cp_en        = cp_en_q;
    assign locked       = locked_q;
    assign fail         = fail_q;
    assign unlock_pulse = unlock_q;
    assign state        = state_q;

endmodule

// File: tb/tb_pfd_lock_ctrl.sv
// Directed self-checking bench for pfd_lock_ctrl: start-up, lock, unlock, timeout, reset.
module tb_pfd_lock_ctrl;

    // Observation vector: {pfd_rstb, cp_en, locked, fail, unlock_pulse, state[2:0]}
    localparam logic [7:0] OIdle   = 8'b00000_000;
    localparam logic [7:0] OPrst   = 8'b00000_001;
    localparam logic [7:0] OAcq    = 8'b11000_010;
    localparam logic [7:0] OLocked = 8'b11100_011;
    localparam logic [7:0] OFail   = 8'b00010_100;
    localparam logic [7:0] OUnlock = 8'b11001_010;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0, up_smp = 1'b0, dn_smp = 1'b0;
    logic       pfd_rstb, cp_en, locked, fail, unlock_pulse;
    logic [2:0] state;
    logic       en2 = 1'b0, up2 = 1'b0, dn2 = 1'b0;
    logic       pfd_rstb2, cp_en2, locked2, fail2, unlock2;
    logic [2:0] state2;
    logic [7:0] obs, obs2;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    assign obs  = {pfd_rstb, cp_en, locked, fail, unlock_pulse, state};
    assign obs2 = {pfd_rstb2, cp_en2, locked2, fail2, unlock2, state2};

    pfd_lock_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .up_smp       (up_smp),
        .dn_smp       (dn_smp),
        .pfd_rstb     (pfd_rstb),
        .cp_en        (cp_en),
        .locked       (locked),
        .fail         (fail),
        .unlock_pulse (unlock_pulse),
        .state        (state)
    );

    // Short timeout so lock and timeout can coincide: bad at ACQ cycle 4, 8 good to cycle 12.
    pfd_lock_ctrl #(
        .RST_CYC    (2),
        .LOCK_CNT   (8),
        .UNLOCK_CNT (4),
        .TIMEOUT    (12),
        .CNT_W      (16)
    ) dut2 (
        .clk          (clk),
        .reset        (reset),
        .en           (en2),
        .up_smp       (up2),
        .dn_smp       (dn2),
        .pfd_rstb     (pfd_rstb2),
        .cp_en        (cp_en2),
        .locked       (locked2),
        .fail         (fail2),
        .unlock_pulse (unlock2),
        .state        (state2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_chk++;
        if (obs !== OIdle) begin
            n_fail++; $display("FAIL reset_values: got %b want %b", obs, OIdle);
        end
        step(); step();
        reset = 1'b0;
        step();
        n_chk++;
        if (obs !== OIdle) begin
            n_fail++; $display("FAIL idle_en0: got %b want %b", obs, OIdle);
        end
    endtask

    task automatic test_startup();
        en = 1'b1;
        step();
        n_chk++;
        if (obs !== OPrst) begin
            n_fail++; $display("FAIL prst_entry: got %b want %b", obs, OPrst);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            n_chk++;
            if (obs !== OPrst) begin
                n_fail++; $display("FAIL prst_hold%0d: got %b want %b", i, obs, OPrst);
            end
        end
        step();
        n_chk++;
        if (obs !== OAcq) begin
            n_fail++; $display("FAIL rstb_rise_4: got %b want %b", obs, OAcq);
        end
        for (int i = 1; i <= 63; i++) step();
        n_chk++;
        if (obs !== OAcq) begin
            n_fail++; $display("FAIL acq_63: got %b want %b", obs, OAcq);
        end
        step();
        n_chk++;
        if (obs !== OLocked) begin
            n_fail++; $display("FAIL lock_64: got %b want %b", obs, OLocked);
        end
    endtask

    task automatic test_unlock();
        dn_smp = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_chk++;
            if (obs !== OLocked) begin
                n_fail++; $display("FAIL bad3_hold%0d: got %b want %b", i, obs, OLocked);
            end
        end
        dn_smp = 1'b0;
        step();
        dn_smp = 1'b1;
        for (int i = 1; i <= 3; i++) step();
        n_chk++;
        if (obs !== OLocked) begin
            n_fail++; $display("FAIL bad_run_restart: got %b want %b", obs, OLocked);
        end
        step();
        n_chk++;
        if (obs !== OUnlock) begin
            n_fail++; $display("FAIL unlock_edge: got %b want %b", obs, OUnlock);
        end
        dn_smp = 1'b0;
        step();
        n_chk++;
        if (obs !== OAcq) begin
            n_fail++; $display("FAIL unlock_one_cycle: got %b want %b", obs, OAcq);
        end
    endtask

    // Continues from ACQ with one good cycle already counted after the unlock.
    task automatic test_good_restart();
        for (int i = 1; i <= 62; i++) step();
        up_smp = 1'b1;
        step();
        up_smp = 1'b0;
        n_chk++;
        if (obs !== OAcq) begin
            n_fail++; $display("FAIL bad_at_63: got %b want %b", obs, OAcq);
        end
        for (int i = 1; i <= 63; i++) step();
        n_chk++;
        if (obs !== OAcq) begin
            n_fail++; $display("FAIL good_63_after_bad: got %b want %b", obs, OAcq);
        end
        step();
        n_chk++;
        if (obs !== OLocked) begin
            n_fail++; $display("FAIL relock_64: got %b want %b", obs, OLocked);
        end
    endtask

    task automatic test_reset_mid_locked();
        #2;
        reset = 1'b1;
        #1;
        n_chk++;
        if (obs !== OIdle) begin
            n_fail++; $display("FAIL async_reset: got %b want %b", obs, OIdle);
        end
        step();
        reset = 1'b0;
        step();
        n_chk++;
        if (obs !== OPrst) begin
            n_fail++; $display("FAIL restart_prst: got %b want %b", obs, OPrst);
        end
    endtask

    task automatic test_timeout();
        for (int i = 1; i <= 4; i++) step();
        n_chk++;
        if (obs !== OAcq) begin
            n_fail++; $display("FAIL tmo_acq_entry: got %b want %b", obs, OAcq);
        end
        for (int i = 1; i <= 4095; i++) begin
            up_smp = i[0];
            step();
        end
        n_chk++;
        if (obs !== OAcq) begin
            n_fail++; $display("FAIL tmo_4095: got %b want %b", obs, OAcq);
        end
        up_smp = 1'b0;
        step();
        n_chk++;
        if (obs !== OFail) begin
            n_fail++; $display("FAIL tmo_4096: got %b want %b", obs, OFail);
        end
`ifndef PFD_LOCK_AUTORETRY_EN
        for (int i = 1; i <= 20; i++) step();
        n_chk++;
        if (obs !== OFail) begin
            n_fail++; $display("FAIL fail_terminal: got %b want %b", obs, OFail);
        end
`endif
        en = 1'b0;
        step();
        n_chk++;
        if (obs !== OIdle) begin
            n_fail++; $display("FAIL fail_to_idle: got %b want %b", obs, OIdle);
        end
    endtask

    task automatic test_lock_vs_timeout();
        en2 = 1'b1;
        step();
        n_chk++;
        if (obs2 !== OPrst) begin
            n_fail++; $display("FAIL lt_prst: got %b want %b", obs2, OPrst);
        end
        step(); step();
        n_chk++;
        if (obs2 !== OAcq) begin
            n_fail++; $display("FAIL lt_acq: got %b want %b", obs2, OAcq);
        end
        for (int i = 1; i <= 3; i++) step();
        up2 = 1'b1;
        step();
        up2 = 1'b0;
        for (int i = 1; i <= 7; i++) step();
        n_chk++;
        if (obs2 !== OAcq) begin
            n_fail++; $display("FAIL lt_cycle11: got %b want %b", obs2, OAcq);
        end
        step();
        n_chk++;
        if (obs2 !== OLocked) begin
            n_fail++; $display("FAIL lt_lock_wins: got %b want %b", obs2, OLocked);
        end
        en2 = 1'b0;
        step();
        n_chk++;
        if (obs2 !== OIdle) begin
            n_fail++; $display("FAIL lt_en_exit: got %b want %b", obs2, OIdle);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_unlock();
        test_good_restart();
        test_reset_mid_locked();
        test_timeout();
        test_lock_vs_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
